// File: rtl/digital_clock_time_ctrl_pkg.sv
// Shared encodings and limits for the digital-clock time controller.
package digital_clock_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    typedef enum logic [1:0] {
        StRun     = MODE_RUN,
        StSetHour = MODE_SET_HOUR,
        StSetMin  = MODE_SET_MIN
    } mode_e;

endpackage

// File: rtl/digital_clock_time_ctrl_if.sv
// Key inputs and display outputs of the time controller.
interface digital_clock_time_ctrl_if;
    import digital_clock_pkg::*;

    logic               En;
    logic               key_mode;
    logic               key_inc;
    logic [DIGIT_W-1:0] S0, S1, M0, M1, H0, H1;
    logic [1:0]         mode;
    logic               blink;
    logic               chime;

    modport master (
        output En, key_mode, key_inc,
        input  S0, S1, M0, M1, H0, H1, mode, blink, chime
    );

    modport slave (
        input  En, key_mode, key_inc,
        output S0, S1, M0, M1, H0, H1, mode, blink, chime
    );

endinterface

// File: rtl/digital_clock_time_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX -> 00 on inc; tc flags value == MAX.
module bcd_mod_counter
    import digital_clock_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic               CLK,
    input  logic               CR,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units,
    output logic               tc
);

    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_U = DIGIT_W'(MAX % 10);

    logic [DIGIT_W-1:0] tens_q, units_q;

    assign tc    = (tens_q == MAX_T) && (units_q == MAX_U);
    assign tens  = tens_q;
    assign units = units_q;

    always_ff @(posedge CLK) begin
        if (!CR) begin
            tens_q  <= '0;
            units_q <= '0;
        end else if (inc) begin
            if (tc) begin
                tens_q  <= '0;
                units_q <= '0;
            end else if (units_q >= DIGIT_W'(9)) begin
                tens_q  <= tens_q + 1'b1;
                units_q <= '0;
            end else begin
                units_q <= units_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digital_clock_time_ctrl.sv
// hh:mm:ss time chain with RUN/SET_HOUR/SET_MIN key FSM and blink strobe.
// Optional hourly chime enabled by `define DIGITAL_CLOCK_CHIME_EN.
module digital_clock_time_ctrl
    import digital_clock_pkg::*;
#(
    parameter int unsigned DIV       = 50_000_000,
    parameter int unsigned CHIME_CYC = 4
) (
    input  logic                      CLK,
    input  logic                      CR,
    digital_clock_time_ctrl_if.slave  bus
);

    localparam int unsigned    PW        = $clog2(DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0]  HALF_MAX  = PW'(DIV / 2 - 1);

    mode_e          mode_q;
    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  half_q;
    logic           blink_q;

    logic in_run, tick, inc_key, leave_set;
    logic sec_tc, min_tc, unused_hour_tc;
    logic sec_inc, min_inc, hour_inc;

    assign in_run    = (mode_q == StRun);
    assign tick      = (presc_q == PRESC_MAX) && bus.En && in_run;
    // key_mode takes priority: a coincident key_inc is dropped.
    assign inc_key   = bus.key_inc && !bus.key_mode;
    assign leave_set = bus.key_mode && (mode_q == StSetMin);

    assign sec_inc  = tick;
    assign min_inc  = (tick && sec_tc) || (inc_key && (mode_q == StSetMin));
    assign hour_inc = (tick && sec_tc && min_tc) || (inc_key && (mode_q == StSetHour));

    always_ff @(posedge CLK) begin
        if (!CR) begin
            mode_q  <= StRun;
            presc_q <= '0;
            half_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            if (bus.key_mode) begin
                case (mode_q)
                    StRun:     mode_q <= StSetHour;
                    StSetHour: mode_q <= StSetMin;
                    default:   mode_q <= StRun;
                endcase
            end

            if (leave_set) begin
                presc_q <= '0;
            end else if (bus.En && in_run) begin
                presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            end

            // Blink half counter free-runs in SET modes, independent of En.
            if (in_run || leave_set) begin
                half_q  <= '0;
                blink_q <= 1'b0;
            end else if (half_q == HALF_MAX) begin
                half_q  <= '0;
                blink_q <= !blink_q;
            end else begin
                half_q  <= half_q + 1'b1;
            end
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .CLK   (CLK),
        .CR    (CR && !leave_set),
        .inc   (sec_inc),
        .tens  (bus.S1),
        .units (bus.S0),
        .tc    (sec_tc)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .CLK   (CLK),
        .CR    (CR),
        .inc   (min_inc),
        .tens  (bus.M1),
        .units (bus.M0),
        .tc    (min_tc)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .CLK   (CLK),
        .CR    (CR),
        .inc   (hour_inc),
        .tens  (bus.H1),
        .units (bus.H0),
        .tc    (unused_hour_tc)
    );

    assign bus.mode  = mode_q;
    assign bus.blink = blink_q;

`ifdef DIGITAL_CLOCK_CHIME_EN
    localparam int unsigned CW = $clog2(CHIME_CYC + 1);

    // Remaining ticks of chime; reloaded by every mm:ss 59:59 rollover.
    logic [CW-1:0] chime_q;

    always_ff @(posedge CLK) begin
        if (!CR) begin
            chime_q <= '0;
        end else if (tick && sec_tc && min_tc) begin
            chime_q <= CW'(CHIME_CYC);
        end else if (tick && (chime_q != '0)) begin
            chime_q <= chime_q - 1'b1;
        end
    end

    assign bus.chime = (chime_q != '0);
`else
    logic unused_chime_cfg;
    assign unused_chime_cfg = ^CHIME_CYC;
    assign bus.chime        = 1'b0;
`endif

endmodule

// File: tb/tb_digital_clock_time_ctrl.sv
// Directed bench for digital_clock_time_ctrl with DIV=4, CHIME_CYC=2.
module tb_digital_clock_time_ctrl;

    logic CLK;
    logic CR;
    int   n_checks;
    int   n_errors;

    digital_clock_time_ctrl_if dut_if ();

    digital_clock_time_ctrl #(
        .DIV       (4),
        .CHIME_CYC (2)
    ) dut (
        .CLK (CLK),
        .CR  (CR),
        .bus (dut_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [23:0] hms();
        return {dut_if.H1, dut_if.H0, dut_if.M1, dut_if.M0, dut_if.S1, dut_if.S0};
    endfunction

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_mode();
        dut_if.key_mode = 1'b1;
        step(1);
        dut_if.key_mode = 1'b0;
    endtask

    task automatic hold_inc(input int n);
        dut_if.key_inc = 1'b1;
        step(n);
        dut_if.key_inc = 1'b0;
    endtask

    task automatic test_reset();
        CR = 1'b0;
        dut_if.En = 1'b0;
        dut_if.key_mode = 1'b0;
        dut_if.key_inc = 1'b0;
        step(2);
        CR = 1'b1;
        dut_if.En = 1'b1;
        n_checks++;
        if (hms() !== 24'h000000) begin
            n_errors++; $display("FAIL reset_digits: got %h want 000000", hms());
        end
        n_checks++;
        if (dut_if.mode !== 2'd0 || dut_if.blink !== 1'b0 || dut_if.chime !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: mode=%0d blink=%b chime=%b want 0 0 0",
                     dut_if.mode, dut_if.blink, dut_if.chime);
        end
        step(3);
        n_checks++;
        if (hms() !== 24'h000000) begin
            n_errors++; $display("FAIL first_tick_early: got %h want 000000", hms());
        end
        step(1);
        n_checks++;
        if (hms() !== 24'h000001) begin
            n_errors++; $display("FAIL first_tick: got %h want 000001", hms());
        end
    endtask

    task automatic test_rollover();
        pulse_mode();
        hold_inc(23);
        pulse_mode();
        hold_inc(59);
        pulse_mode();
        n_checks++;
        if (hms() !== 24'h235900 || dut_if.mode !== 2'd0) begin
            n_errors++;
            $display("FAIL preload: got %h mode %0d want 235900 mode 0", hms(), dut_if.mode);
        end
        step(58 * 4);
        n_checks++;
        if (hms() !== 24'h235958) begin
            n_errors++; $display("FAIL run_58: got %h want 235958", hms());
        end
        step(4);
        step(3);
        n_checks++;
        if (hms() !== 24'h235959) begin
            n_errors++; $display("FAIL pre_roll: got %h want 235959", hms());
        end
        step(1);
        n_checks++;
        if (hms() !== 24'h000000) begin
            n_errors++; $display("FAIL rollover: got %h want 000000", hms());
        end
`ifdef DIGITAL_CLOCK_CHIME_EN
        n_checks++;
        if (dut_if.chime !== 1'b1) begin
            n_errors++; $display("FAIL chime_on: got %b want 1", dut_if.chime);
        end
        step(7);
        n_checks++;
        if (dut_if.chime !== 1'b1) begin
            n_errors++; $display("FAIL chime_hold: got %b want 1", dut_if.chime);
        end
        step(1);
        n_checks++;
        if (dut_if.chime !== 1'b0) begin
            n_errors++; $display("FAIL chime_off: got %b want 0", dut_if.chime);
        end
        step(4);
`else
        n_checks++;
        if (dut_if.chime !== 1'b0) begin
            n_errors++; $display("FAIL chime_tied: got %b want 0", dut_if.chime);
        end
        step(12);
`endif
        n_checks++;
        if (hms() !== 24'h000003) begin
            n_errors++; $display("FAIL post_roll: got %h want 000003", hms());
        end
    endtask

    task automatic test_set_hour();
        pulse_mode();
        n_checks++;
        if (dut_if.mode !== 2'd1 || dut_if.blink !== 1'b0) begin
            n_errors++;
            $display("FAIL set_hour_entry: mode=%0d blink=%b want 1 0", dut_if.mode, dut_if.blink);
        end
        step(2);
        n_checks++;
        if (dut_if.blink !== 1'b1) begin
            n_errors++; $display("FAIL blink_toggle: got %b want 1", dut_if.blink);
        end
        hold_inc(25);
        n_checks++;
        if (hms() !== 24'h010003) begin
            n_errors++; $display("FAIL hour_inc25: got %h want 010003", hms());
        end
        step(9);
        n_checks++;
        if (hms() !== 24'h010003) begin
            n_errors++; $display("FAIL no_tick_set: got %h want 010003", hms());
        end
    endtask

    task automatic test_set_min();
        pulse_mode();
        n_checks++;
        if (dut_if.mode !== 2'd2) begin
            n_errors++; $display("FAIL set_min_entry: mode=%0d want 2", dut_if.mode);
        end
        hold_inc(59);
        n_checks++;
        if (hms() !== 24'h015903) begin
            n_errors++; $display("FAIL min_59: got %h want 015903", hms());
        end
        hold_inc(1);
        n_checks++;
        if (hms() !== 24'h010003) begin
            n_errors++; $display("FAIL min_wrap: got %h want 010003", hms());
        end
        pulse_mode();
        n_checks++;
        if (hms() !== 24'h010000 || dut_if.mode !== 2'd0 || dut_if.blink !== 1'b0) begin
            n_errors++;
            $display("FAIL leave_set: got %h mode %0d blink %b want 010000 0 0",
                     hms(), dut_if.mode, dut_if.blink);
        end
        step(3);
        n_checks++;
        if (hms() !== 24'h010000) begin
            n_errors++; $display("FAIL presc_clear_early: got %h want 010000", hms());
        end
        step(1);
        n_checks++;
        if (hms() !== 24'h010001) begin
            n_errors++; $display("FAIL presc_clear: got %h want 010001", hms());
        end
    endtask

    task automatic test_simultaneous();
        hold_inc(1);
        n_checks++;
        if (hms() !== 24'h010001 || dut_if.mode !== 2'd0) begin
            n_errors++; $display("FAIL inc_in_run: got %h want 010001", hms());
        end
        pulse_mode();
        dut_if.key_inc = 1'b1;
        pulse_mode();
        dut_if.key_inc = 1'b0;
        n_checks++;
        if (dut_if.mode !== 2'd2 || hms() !== 24'h010001) begin
            n_errors++;
            $display("FAIL mode_wins: got mode %0d %h want mode 2 010001", dut_if.mode, hms());
        end
        pulse_mode();
        n_checks++;
        if (dut_if.mode !== 2'd0 || hms() !== 24'h010000) begin
            n_errors++;
            $display("FAIL back_to_run: got mode %0d %h want mode 0 010000", dut_if.mode, hms());
        end
    endtask

    task automatic test_en_freeze();
        step(2);
        dut_if.En = 1'b0;
        step(10);
        n_checks++;
        if (hms() !== 24'h010000) begin
            n_errors++; $display("FAIL en_freeze: got %h want 010000", hms());
        end
        dut_if.En = 1'b1;
        step(1);
        n_checks++;
        if (hms() !== 24'h010000) begin
            n_errors++; $display("FAIL en_resume_early: got %h want 010000", hms());
        end
        step(1);
        n_checks++;
        if (hms() !== 24'h010001) begin
            n_errors++; $display("FAIL en_resume: got %h want 010001", hms());
        end
        pulse_mode();
        step(2);
        CR = 1'b0;
        step(1);
        CR = 1'b1;
        n_checks++;
        if (hms() !== 24'h000000 || dut_if.mode !== 2'd0 || dut_if.blink !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: got %h mode %0d blink %b want 000000 0 0",
                     hms(), dut_if.mode, dut_if.blink);
        end
        step(3);
        n_checks++;
        if (hms() !== 24'h000000) begin
            n_errors++; $display("FAIL post_reset_early: got %h want 000000", hms());
        end
        step(1);
        n_checks++;
        if (hms() !== 24'h000001) begin
            n_errors++; $display("FAIL post_reset_tick: got %h want 000001", hms());
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_rollover();
        test_set_hour();
        test_set_min();
        test_simultaneous();
        test_en_freeze();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
